// File: rtl/window_feeder_if.sv
// window_feeder_if
// Groups the pixel-stream and window-presentation signals of the window
// feeder into a single bundle.
//   pix_in / pix_valid / pix_ready    raster pixel stream into the feeder
//   window_data_in[i][j]              8-bit pixel of the presented window
//   window_data_ready                 a window is presented and stable
//   done_with_window_data             correlator has consumed the window
//   win_idx                           index of the presented window
//   region_done                       pulse after the last window is consumed
// Modports: master = the feeder itself, slave = the pixel source/correlator side.
interface window_feeder_if #(
  parameter int WIN = 16
);
  logic [7:0]                   pix_in;
  logic                         pix_valid;
  logic                         pix_ready;
  logic [WIN-1:0][WIN-1:0][7:0] window_data_in;
  logic                         window_data_ready;
  logic                         done_with_window_data;
  logic [8:0]                   win_idx;
  logic                         region_done;

  modport master (
    input  pix_in, pix_valid, done_with_window_data,
    output pix_ready, window_data_in, window_data_ready, win_idx, region_done
  );

  modport slave (
    output pix_in, pix_valid, done_with_window_data,
    input  pix_ready, window_data_in, window_data_ready, win_idx, region_done
  );
endinterface

// File: rtl/window_feeder.sv
// window_feeder
// Buffers one REG_W x REG_H search region arriving as a raster pixel stream,
// then presents every WIN x WIN sub-window of it, one at a time, to the NCC
// correlator. Windows are scanned column offset first, then row offset.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    asynchronous active-high reset
//   flush  synchronous abort: discard the region and return to IDLE
//   bus    window_feeder_if master modport (pixel stream in, window out)
module window_feeder #(
  parameter int REG_W = 30,
  parameter int REG_H = 25,
  parameter int WIN   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  window_feeder_if.master bus
);

  localparam int NCOL = REG_W - WIN + 1;
  localparam int NROW = REG_H - WIN + 1;
  localparam int NPIX = REG_W * REG_H;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0] pix_count;
  logic [3:0] col_off;
  logic [3:0] row_off;
  logic       region_done_q;

  logic [7:0] buffer [NPIX];

  logic accept;
  logic last_pix;
  logic advance;
  logic last_win;
  logic pix_ready_c;
  logic win_ready_c;

  logic [WIN-1:0][WIN-1:0][7:0] win;

  assign accept   = (state == LOAD) && bus.pix_valid;
  assign last_pix = (pix_count == 10'(NPIX - 1));
  assign advance  = (state == SCAN) && bus.done_with_window_data;
  assign last_win = (row_off == 4'(NROW - 1)) && (col_off == 4'(NCOL - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides every other event
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = LOAD;
        LOAD:    if (accept && last_pix) state_next = SCAN;
        SCAN:    if (advance && last_win) state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded handshake outputs
  always_comb begin
    pix_ready_c = 1'b0;
    win_ready_c = 1'b0;
    case (state)
      LOAD:    pix_ready_c = 1'b1;
      SCAN:    win_ready_c = 1'b1;
      default: ;
    endcase
  end

  // Pixel counter, window offsets and the region_done pulse. Offsets are
  // cleared both on entering SCAN and after the last window, so win_idx
  // reads 0 whenever no window is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count     <= '0;
      col_off       <= '0;
      row_off       <= '0;
      region_done_q <= 1'b0;
    end else begin
      region_done_q <= 1'b0;
      if (flush) begin
        pix_count <= '0;
        col_off   <= '0;
        row_off   <= '0;
      end else if (accept) begin
        if (last_pix) begin
          pix_count <= '0;
          col_off   <= '0;
          row_off   <= '0;
        end else begin
          pix_count <= pix_count + 10'd1;
        end
      end else if (advance) begin
        if (last_win) begin
          col_off       <= '0;
          row_off       <= '0;
          region_done_q <= 1'b1;
        end else if (col_off < 4'(NCOL - 1)) begin
          col_off <= col_off + 4'd1;
        end else begin
          col_off <= '0;
          row_off <= row_off + 4'd1;
        end
      end
    end
  end

  // Region buffer; no reset because its contents only matter after a full load
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      buffer[pix_count] <= bus.pix_in;
    end
  end

  // Combinational window selection at the current offsets
  always_comb begin
    win = '0;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        win[i][j] = buffer[10'((int'(row_off) + i) * REG_W + int'(col_off) + j)];
      end
    end
  end

  assign bus.pix_ready         = pix_ready_c;
  assign bus.window_data_ready = win_ready_c;
  assign bus.window_data_in    = win;
  assign bus.win_idx           = 9'(int'(row_off) * NCOL + int'(col_off));
  assign bus.region_done       = region_done_q;

endmodule

// File: doc/window_feeder.md
# window_feeder

Buffers one search region of 8-bit luminance pixels arriving as a raster stream, then presents every 16×16 sub-window of that region, one at a time, to the NCC correlator's window port. It sits directly upstream of the correlator. It drives `window_data_in`/`window_data_ready` and consumes `done_with_window_data`. With default parameters one region yields exactly 150 windows, which matches the correlator's 150-window index count.

## Interface
- `REG_W`, 30, search-region width in pixels.
- `REG_H`, 25, search-region height in pixels.
- `WIN`, 16, window edge in pixels. Fixed at 16 to match the correlator grid.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous abort; discards the region and returns to IDLE.
- `pix_in`  in  8  raster-order pixel, row 0 column 0 first.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts a pixel this cycle.
- `window_data_in`  out  8×[15:0][15:0]  current window; element [i][j] = region[row_off+i][col_off+j].
- `window_data_ready`  out  1  a window is presented and stable.
- `done_with_window_data`  in  1  correlator has consumed the window.
- `win_idx`  out  9  index of the presented window, row_off*(REG_W-WIN+1)+col_off.
- `region_done`  out  1  one-cycle pulse after the last window of a region is consumed.

## Operation
- Derived counts: NCOL = REG_W-WIN+1 = 15; NROW = REG_H-WIN+1 = 10; NPIX = REG_W*REG_H = 750.
- The region buffer holds NPIX bytes. It is written only in LOAD and is read-only in SCAN.
- Registers:
  - pixel counter, 10 bits, 0..NPIX-1.
  - `col_off`, 4 bits, 0..NCOL-1.
  - `row_off`, 4 bits, 0..NROW-1.
- State IDLE: `pix_ready`=0. Go to LOAD unconditionally on the next clock.
- State LOAD: `pix_ready`=1.
  - A pixel is accepted on a clock where `pix_valid`&`pix_ready`=1. It is written to buffer[count] and the count increments.
  - When the accepted pixel is number NPIX-1: clear the count, clear both offsets, go to SCAN.
- State SCAN: `window_data_ready`=1.
  - `window_data_in` is a combinational selection from the buffer at (`row_off`, `col_off`).
  - On a clock where `done_with_window_data`=1:
    - If `col_off`<NCOL-1, increment `col_off`.
    - Otherwise clear `col_off` and increment `row_off`.
    - If the window just consumed is the last one (`row_off`=NROW-1, `col_off`=NCOL-1): go to LOAD and register `region_done`=1 for one cycle.
- `done_with_window_data` is ignored outside SCAN. `pix_valid` is ignored outside LOAD.
- `flush` has priority over every other event, including a simultaneous done or a pixel accept:
  - State goes to IDLE; counters and offsets clear; `region_done` is not pulsed.
  - Buffer contents are don't-care.
- No arithmetic overflow is possible. Counters are compared against terminal values before incrementing, never allowed to wrap.

## Timing
- Reset values: state IDLE; `pix_ready`=0; `window_data_ready`=0; `win_idx`=0; `region_done`=0; counters and offsets 0. `window_data_in` is don't-care until the first SCAN.
- After reset deasserts, `pix_ready`=1 from the second clock edge onward.
- After the 750th pixel is accepted, `window_data_ready`=1 in the very next cycle, with window 0.
- Handshake sequence:
  - Cycle t: `window_data_ready`=1; the correlator loads the window.
  - Cycle t+1: the correlator asserts done; the edge at the end of t+1 advances the offsets.
  - Cycle t+2: a new window is presented with `window_data_ready` still 1.
  - `window_data_ready` stays high continuously through a region. Window data and `win_idx` change only on edges where done is sampled high.
  - Throughput is 2 cycles per window, 300 cycles per region in SCAN.
- After the last done: `window_data_ready`=0, `pix_ready`=1, and `region_done`=1 in the same next cycle.
- An `rst` assertion mid-LOAD or mid-SCAN forces all reset values immediately, without waiting for a clock.

## Test plan
- **Load and first window.** Reset, then stream pixels p=(r*30+c) mod 256 with `pix_valid` held at 1. Required: `pix_ready` is 1 for exactly 750 accepts; the next cycle has `window_data_ready`=1, `win_idx`=0, [0][0]=0, [15][15]=209.
- **Full scan.** Respond with done one cycle after each ready window. Required:
  - `win_idx` sequence 0..149.
  - `win_idx` 14 → [0][0]=14.
  - `win_idx` 15 → [0][0]=30.
  - `win_idx` 149 → [0][0]=28, [15][15]=237.
  - `region_done` pulses once, coincident with `pix_ready` returning to 1, 300 cycles after the first ready window.
- **Stalled consumer.** Hold done low for 20 cycles on window 5. Required: `win_idx`=5 and data unchanged throughout; it advances to 6 only after done.
- **Bubbled input.** Toggle `pix_valid` on alternate cycles. Required: only valid cycles count; SCAN is entered after the 750th valid pixel with the same window contents as the load-and-first-window case.
- **Flush conflicts.** Assert flush together with done on window 149. Required: no `region_done`; state IDLE, then LOAD; `win_idx`=0.
- **Async reset mid-stream.** Assert `rst` mid-LOAD at pixel 400 (asynchronously). Required: outputs reach reset values before the next edge; the next load requires all 750 pixels again.
